// File: rtl/iq_pkg.sv
// Shared types and defaults for the instruction queue between decode and dispatch.
// Holds the queue entry layout and the opcode shown when nothing is presented.
package iq_pkg;

   localparam int IQ_OP_W  = 5;
   localparam int IQ_REG_W = 5;
   localparam int IQ_IMM_W = 32;

   localparam logic [IQ_OP_W-1:0] NOP_OP = 5'h1F;

   typedef struct packed {
      logic [IQ_OP_W-1:0]  op;
      logic [IQ_REG_W-1:0] rs1;
      logic [IQ_REG_W-1:0] rs2;
      logic [IQ_REG_W-1:0] rd;
      logic [IQ_IMM_W-1:0] imm;
      logic                has_imm;
   } iq_entry_t;

endpackage

// File: rtl/iq_fifo_ptr.sv
// Modulo-DEPTH pointer register (iq_ptr), used for both head and tail of the instruction queue.
// clear is synchronous and takes priority over inc.
module iq_ptr #(
   parameter int DEPTH = 16,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);

   // DEPTH is a power of two, so the natural binary wrap is the modulo.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + 1'b1;
      end
   end

endmodule

// File: rtl/iq_fifo.sv
// In-order instruction queue with valid/ready enqueue, flush, occupancy and almost-full outputs.
// Optional empty-queue bypass is enabled by defining IQ_BYPASS_EN.
module iq_fifo
   import iq_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int OP_W      = IQ_OP_W,
   parameter int REG_W     = IQ_REG_W,
   parameter int IMM_W     = IQ_IMM_W,
   parameter int AFULL_LVL = DEPTH - 2,
   localparam int PTR_W    = $clog2(DEPTH),
   localparam int CNT_W    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             enq_valid,
   input  logic [OP_W-1:0]  enq_op,
   input  logic [REG_W-1:0] enq_rs1,
   input  logic [REG_W-1:0] enq_rs2,
   input  logic [REG_W-1:0] enq_rd,
   input  logic [IMM_W-1:0] enq_imm,
   input  logic             enq_has_imm,
   output logic             enq_ready,
   input  logic             rs_full,
   input  logic             rob_full,
   output logic             deq_valid,
   output logic [OP_W-1:0]  deq_op,
   output logic [REG_W-1:0] deq_rs1,
   output logic [REG_W-1:0] deq_rs2,
   output logic [REG_W-1:0] deq_rd,
   output logic [IMM_W-1:0] deq_imm,
   output logic             deq_has_imm,
   output logic             shooted,
   output logic [CNT_W-1:0] count,
   output logic             iq_full,
   output logic             almost_full
);

   iq_entry_t        mem [DEPTH];
   iq_entry_t        head_entry;
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic             deq_ready;
   logic             queue_valid;
   logic             bypass;
   logic             deq_fire;
   logic             push;
   logic             pop;

   assign iq_full     = (count == CNT_W'(DEPTH));
   assign almost_full = (count >= CNT_W'(AFULL_LVL));
   assign enq_ready   = !iq_full;
   assign deq_ready   = !rs_full && !rob_full;
   assign queue_valid = (count != '0);

`ifdef IQ_BYPASS_EN
   assign bypass = !queue_valid && enq_valid && deq_ready && !flush;
`else
   assign bypass = 1'b0;
`endif

   assign deq_fire = deq_valid && deq_ready;
   // A bypassed instruction is consumed directly and never touches storage or pointers.
   assign pop      = deq_fire && !bypass;
   assign push     = enq_valid && enq_ready && !bypass && !flush;
   assign head_entry = mem[head];

   iq_ptr #(.DEPTH(DEPTH)) u_head (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (pop),
      .ptr   (head)
   );

   iq_ptr #(.DEPTH(DEPTH)) u_tail (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (flush),
      .inc   (push),
      .ptr   (tail)
   );

   always_ff @(posedge clk) begin
      if (push) begin
         mem[tail] <= '{op: enq_op, rs1: enq_rs1, rs2: enq_rs2, rd: enq_rd,
                        imm: enq_imm, has_imm: enq_has_imm};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count   <= '0;
         shooted <= 1'b0;
      end else if (flush) begin
         count   <= '0;
         shooted <= 1'b0;
      end else begin
         shooted <= deq_fire;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_comb begin
      deq_valid   = 1'b0;
      deq_op      = NOP_OP;
      deq_rs1     = '0;
      deq_rs2     = '0;
      deq_rd      = '0;
      deq_imm     = '0;
      deq_has_imm = 1'b0;
      if (bypass) begin
         deq_valid   = 1'b1;
         deq_op      = enq_op;
         deq_rs1     = enq_rs1;
         deq_rs2     = enq_rs2;
         deq_rd      = enq_rd;
         deq_imm     = enq_imm;
         deq_has_imm = enq_has_imm;
      end else if (queue_valid) begin
         deq_valid   = 1'b1;
         deq_op      = head_entry.op;
         deq_rs1     = head_entry.rs1;
         deq_rs2     = head_entry.rs2;
         deq_rd      = head_entry.rd;
         deq_imm     = head_entry.imm;
         deq_has_imm = head_entry.has_imm;
      end
   end

endmodule

// File: tb/tb_iq_fifo.sv
// Randomized self-checking bench for iq_fifo against a queue-based reference model.
// Define IQ_BYPASS_EN for both bench and RTL to exercise the empty-queue bypass.
module tb_iq_fifo;

   localparam int DEPTH = 16;

   typedef struct {
      logic [4:0]  op, rs1, rs2, rd;
      logic [31:0] imm;
      logic        has_imm;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        enq_valid = 1'b0;
   logic [4:0]  enq_op = '0, enq_rs1 = '0, enq_rs2 = '0, enq_rd = '0;
   logic [31:0] enq_imm = '0;
   logic        enq_has_imm = 1'b0;
   logic        rs_full = 1'b0, rob_full = 1'b0;
   logic        enq_ready, deq_valid, deq_has_imm, shooted, iq_full, almost_full;
   logic [4:0]  deq_op, deq_rs1, deq_rs2, deq_rd;
   logic [31:0] deq_imm;
   logic [4:0]  count;

   int   n_cmp = 0;
   int   n_fail = 0;
   ent_t q[$];
   logic exp_shooted = 1'b0;

   iq_fifo #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .enq_valid(enq_valid), .enq_op(enq_op), .enq_rs1(enq_rs1), .enq_rs2(enq_rs2),
      .enq_rd(enq_rd), .enq_imm(enq_imm), .enq_has_imm(enq_has_imm), .enq_ready(enq_ready),
      .rs_full(rs_full), .rob_full(rob_full),
      .deq_valid(deq_valid), .deq_op(deq_op), .deq_rs1(deq_rs1), .deq_rs2(deq_rs2),
      .deq_rd(deq_rd), .deq_imm(deq_imm), .deq_has_imm(deq_has_imm),
      .shooted(shooted), .count(count), .iq_full(iq_full), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit exp_bypass();
`ifdef IQ_BYPASS_EN
      return (q.size() == 0) && enq_valid && !rs_full && !rob_full && !flush;
`else
      return 1'b0;
`endif
   endfunction

   function automatic ent_t cur_enq();
      ent_t e;
      e.op = enq_op; e.rs1 = enq_rs1; e.rs2 = enq_rs2; e.rd = enq_rd;
      e.imm = enq_imm; e.has_imm = enq_has_imm;
      return e;
   endfunction

   task automatic apply_stimulus(input logic valid, input logic [4:0] op);
      enq_valid   = valid;
      enq_op      = op;
      enq_rs1     = 5'($urandom);
      enq_rs2     = 5'($urandom);
      enq_rd      = 5'($urandom);
      enq_imm     = $urandom;
      enq_has_imm = 1'($urandom);
   endtask

   // Expected outputs follow from queue contents plus this cycle's inputs.
   task automatic check_output();
      ent_t e;
      bit   byp;
      bit   has;
      byp = exp_bypass();
      has = q.size() > 0;
      e.op = 5'h1F; e.rs1 = '0; e.rs2 = '0; e.rd = '0; e.imm = '0; e.has_imm = 1'b0;
      if (byp) e = cur_enq();
      else if (has) e = q[0];
      cmp("deq_valid", deq_valid, byp || has);
      cmp("deq_op", deq_op, e.op);
      cmp("deq_rs1", deq_rs1, e.rs1);
      cmp("deq_rs2", deq_rs2, e.rs2);
      cmp("deq_rd", deq_rd, e.rd);
      cmp("deq_imm", deq_imm, e.imm);
      cmp("deq_has_imm", deq_has_imm, e.has_imm);
      cmp("count", count, q.size());
      cmp("iq_full", iq_full, q.size() == DEPTH);
      cmp("almost_full", almost_full, q.size() >= DEPTH - 2);
      cmp("enq_ready", enq_ready, q.size() != DEPTH);
      cmp("shooted", shooted, exp_shooted);
   endtask

   task automatic model_advance();
      bit byp;
      bit fire;
      int n;
      byp  = exp_bypass();
      n    = q.size();
      fire = (n > 0 || byp) && !rs_full && !rob_full;
      if (!rst_n || flush) begin
         q.delete();
         exp_shooted = 1'b0;
      end else begin
         exp_shooted = fire;
         if (fire && !byp) void'(q.pop_front());
         if (enq_valid && n < DEPTH && !byp) q.push_back(cur_enq());
      end
   endtask

   // Inputs are set just after a falling edge; this checks, advances the model, and returns at the next falling edge.
   task automatic cycle();
      #1;
      check_output();
      model_advance();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int shot;

      @(negedge clk);
      #1;
      cmp("rst_count", count, 0);
      cmp("rst_deq_valid", deq_valid, 0);
      cmp("rst_deq_op", deq_op, 5'h1F);
      cmp("rst_enq_ready", enq_ready, 1);
      cmp("rst_shooted", shooted, 0);
      cmp("rst_iq_full", iq_full, 0);
      cmp("rst_almost_full", almost_full, 0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

      // Fill with dispatch blocked; the 17th enqueue must be refused.
      rs_full = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i == 13) cmp("afull_at_13", almost_full, 0);
         if (i == 14) cmp("afull_at_14", almost_full, 1);
         apply_stimulus(1'b1, 5'(i));
         cycle();
      end
      cmp("fill_count", count, 16);
      cmp("fill_iq_full", iq_full, 1);
      cmp("fill_enq_ready", enq_ready, 0);

      // Drain in order.
      apply_stimulus(1'b0, 5'd0);
      rs_full = 1'b0;
      shot = 0;
      for (int i = 0; i < 16; i++) begin
         cmp("drain_op", deq_op, 5'(i));
         cycle();
         if (shooted) shot++;
      end
      cmp("drain_shooted_cycles", shot, 16);
      cmp("drain_count", count, 0);
      cycle();

      // Bursts across pointer wrap.
      for (int b = 0; b < 5; b++) begin
         rs_full = 1'b1;
         for (int i = 0; i < 10; i++) begin
            apply_stimulus(1'b1, 5'($urandom));
            cycle();
         end
         apply_stimulus(1'b0, 5'd0);
         rs_full = 1'b0;
         for (int i = 0; i < 10; i++) cycle();
      end

      // Steady state at occupancy 8 with enqueue and dequeue every cycle.
      rs_full = 1'b1;
      for (int i = 0; i < 8; i++) begin
         apply_stimulus(1'b1, 5'($urandom));
         cycle();
      end
      rs_full = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cmp("steady_count", count, 8);
         apply_stimulus(1'b1, 5'($urandom));
         cycle();
      end
      apply_stimulus(1'b0, 5'd0);
      for (int i = 0; i < 8; i++) cycle();

      // Flush at occupancy 5 with an enqueue in the same cycle.
      rs_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         apply_stimulus(1'b1, 5'($urandom));
         cycle();
      end
      cmp("preflush_count", count, 5);
      flush = 1'b1;
      apply_stimulus(1'b1, 5'd9);
      cycle();
      flush = 1'b0;
      apply_stimulus(1'b0, 5'd0);
      cmp("flush_count", count, 0);
      cmp("flush_deq_valid", deq_valid, 0);
      rs_full = 1'b0;
      cycle();

      // Random traffic: an enqueue-heavy stretch, then a dequeue-heavy one.
      for (int i = 0; i < 3000; i++) begin
         apply_stimulus((i < 1500) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0),
                        5'($urandom));
         rs_full  = ($urandom_range(2) == 0);
         rob_full = ($urandom_range(4) == 0);
         flush    = ($urandom_range(63) == 0);
         cycle();
      end
      flush = 1'b0;
      rob_full = 1'b0;

      // Asynchronous reset in the middle of a burst.
      rs_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         apply_stimulus(1'b1, 5'($urandom));
         cycle();
      end
      #2 rst_n = 1'b0;
      #1;
      cmp("async_rst_count", count, 0);
      cmp("async_rst_deq_valid", deq_valid, 0);
      cmp("async_rst_deq_op", deq_op, 5'h1F);
      cmp("async_rst_enq_ready", enq_ready, 1);
      q.delete();
      exp_shooted = 1'b0;
      apply_stimulus(1'b0, 5'd0);
      rs_full = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle();

`ifdef IQ_BYPASS_EN
      apply_stimulus(1'b1, 5'd7);
      #1;
      cmp("bypass_deq_valid", deq_valid, 1);
      cmp("bypass_deq_op", deq_op, 5'd7);
      cycle();
      apply_stimulus(1'b0, 5'd0);
      cmp("bypass_count", count, 0);
      cmp("bypass_shooted", shooted, 1);
      cycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/iq_fifo.md
# iq_fifo

Parametrised instruction queue between decode and dispatch. It buffers decoded instructions (op, rs1, rs2, rd, imm, has_imm) in a circular buffer of DEPTH entries. Instructions issue in order to the reservation station / ROB stage whenever neither is full. Compared with the fixed 16-entry queue, it adds:

- a valid/ready enqueue handshake,
- a pipeline flush,
- exact occupancy and almost-full outputs,
- an optional empty-queue bypass.

## Interface

Parameters:

- DEPTH, 16, number of entries; power of two, ≥4
- OP_W, 5, opcode width
- REG_W, 5, register index width
- IMM_W, 32, immediate width
- AFULL_LVL, DEPTH-2, occupancy at or above which almost_full asserts

Ports:

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard all queued instructions (mispredict)
- enq_valid  in  1  decode presents an instruction
- enq_op / enq_rs1 / enq_rs2 / enq_rd  in  OP_W/REG_W  decoded fields
- enq_imm  in  IMM_W  immediate
- enq_has_imm  in  1  immediate valid
- enq_ready  out  1  queue accepts this cycle
- rs_full, rob_full  in  1  downstream back-pressure
- deq_valid  out  1  head instruction presented to dispatch
- deq_op / deq_rs1 / deq_rs2 / deq_rd / deq_imm / deq_has_imm  out  widths as enq  head fields
- shooted  out  1  registered pulse: an instruction issued in the previous cycle
- count  out  $clog2(DEPTH)+1  current occupancy
- iq_full  out  1  count == DEPTH
- almost_full  out  1  count ≥ AFULL_LVL

## Operation

- Enqueue handshake:
  - enq_ready = !iq_full (combinational from count).
  - Enqueue fires when enq_valid && enq_ready: the entry is written at tail, and tail increments modulo DEPTH.
  - No same-cycle pass-through when full: enq_ready stays low even if a dequeue happens in that cycle.
- Dispatch:
  - deq_ready = !rs_full && !rob_full (internal).
  - Dequeue fires when deq_valid && deq_ready, and head increments modulo DEPTH.
  - deq_* fields are driven combinationally from the head entry.
  - When deq_valid=0, deq_op = NOP_OP (all ones, 5'h1F) and the other deq fields are 0.
- Occupancy:
  - count is updated as count + enq_fire − deq_fire.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - count never exceeds DEPTH and never goes below 0.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined from count, not from pointer equality.
- shooted is a register loaded with deq_fire each cycle.
- Flush:
  - On the next edge, sets head = tail = count = 0 and shooted = 0.
  - Any same-cycle enq is dropped, and enq_ready is still shown as !iq_full.
  - The deq_fire that cycle is still visible downstream combinationally; dispatch must itself gate on flush.
  - Entry contents are not cleared.
- Reset (async, rst_n low):
  - head = tail = count = 0, shooted = 0.
  - Outputs: deq_valid 0, deq_op NOP_OP, other deq fields 0, iq_full 0, almost_full 0 (for AFULL_LVL>0), enq_ready 1.
  - Reset mid-operation discards all contents.

## Timing

- Enqueue-to-dispatch latency is 1 cycle: an entry written at edge N is presented with deq_valid=1 after edge N (without bypass).
- Back-to-back throughput is one enqueue and one dequeue per cycle, sustained at any occupancy below DEPTH.
- Flush takes effect at the first edge where it is sampled high. deq_valid=0 from that edge until a new enqueue.
- rs_full / rob_full act combinationally on the dequeue decision in the same cycle.

## Configuration

- IQ_BYPASS_EN defined:
  - When count==0, enq_valid=1 and deq_ready=1 (and no flush), the enq_* fields drive deq_* combinationally and deq_valid=1.
  - The instruction is consumed without being written; count and pointers are unchanged; shooted pulses next cycle.
  - If deq_ready=0 in that case, the instruction is written normally.
  - Latency on an empty queue becomes 0 cycles.
- IQ_BYPASS_EN undefined: there is no enq-to-deq combinational path, and latency is always 1.

## Structure

- Package iq_pkg holds:
  - NOP_OP;
  - default OP_W, REG_W, IMM_W;
  - the packed struct iq_entry_t {op, rs1, rs2, rd, imm, has_imm}.
- Storage is an array of iq_entry_t.
- One natural sub-module, iq_ptr: a modulo-DEPTH pointer register with increment enable and synchronous clear (flush). It is instantiated for head and tail.

## Test plan

- Reset then idle: count=0, deq_valid=0, deq_op=5'h1F, enq_ready=1, shooted=0.
- Fill with DEPTH=16 and rs_full=1: 16 enqueues (op=0..15). Required result:
  - count reaches 16 and iq_full=1;
  - almost_full asserts at count=14;
  - enq_ready=0;
  - a 17th enqueue is ignored.
- Drain in order: release rs_full with rob_full=0. Required result:
  - deq_op issues 0..15 on consecutive cycles;
  - shooted is high for 16 cycles;
  - count ends at 0.
- Wrap-around: alternate bursts of 10 enqueues and 10 dequeues, 5 times. Required result: in-order op/imm sequence matches a reference model across pointer wrap.
- Simultaneous enqueue and dequeue at count=8: count stays 8 for 20 cycles, and data order is preserved.
- Flush and reset: flush at count=5 with enq_valid=1 gives count=0 and deq_valid=0 next cycle, with the enq dropped. Asserting rst_n low mid-burst gives an immediate return to reset values.
- With IQ_BYPASS_EN, enqueue into an empty queue with downstream ready: deq_valid=1 in the same cycle with matching fields, count stays 0.
